// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM with handshake watchdog.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of running them as NOPs.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [6:0]       opcode,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_en,
    output logic [31:0]      ir,
    output logic [2:0]       state,
    output logic             busy,
    output logic             fault,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    // wd holds at most TIMEOUT-1 before the timeout fires
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          cur;
    state_t          nxt;
    logic [WD_W-1:0] wd;
    logic            wd_exp;
    logic            retire;
    logic            f_rw;
    logic            f_mr;
    logic            f_mw;

    assign opcode = ir[6:0];
    assign state  = cur;
    assign busy   = !(cur inside {IDLE, TRAP, FAULT});
    assign wd_exp = (wd == WD_LAST);

`ifdef ILLEGAL_TRAP_EN
    logic legal_op;
    logic illegal_q;

    assign legal_op = ir[6:0] inside {7'b0110011, 7'b0000011,
                                      7'b0100011, 7'b1100011};
    assign illegal  = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (nxt == TRAP)
            illegal_q <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        nxt      = cur;
        imem_req = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        unique case (cur)
            IDLE: begin
                if (run)
                    nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    nxt = DECODE;
                else if (wd_exp)
                    nxt = FAULT;
            end
            DECODE: begin
                nxt = EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (!legal_op)
                    nxt = TRAP;
`endif
            end
            EXEC: begin
                alu_en = 1'b1;
                if (f_mr || f_mw)
                    nxt = MEM;
                else if (f_rw)
                    nxt = WB;
                else
                    retire = 1'b1;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = f_mw;
                if (dmem_ack) begin
                    if (f_mr)
                        nxt = WB;
                    else
                        retire = 1'b1;
                end else if (wd_exp) begin
                    nxt = FAULT;
                end
            end
            WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            TRAP:  nxt = TRAP;
            FAULT: nxt = FAULT;
        endcase
        if (retire)
            nxt = run ? FETCH : IDLE;
    end

    assign pc_en = retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            ir         <= '0;
            retire_cnt <= '0;
            fault      <= 1'b0;
            wd         <= '0;
            f_rw       <= 1'b0;
            f_mr       <= 1'b0;
            f_mw       <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == FETCH && imem_ack)
                ir <= imem_rdata;
            if (cur == DECODE) begin
                f_rw <= dec_reg_write;
                f_mr <= dec_mem_read;
                f_mw <= dec_mem_write;
            end
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (nxt == FAULT)
                fault <= 1'b1;
            // count only while waiting in the same request state
            if (nxt == cur && (cur == FETCH || cur == MEM))
                wd <= wd + WD_W'(1);
            else
                wd <= '0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer.
// Expected cycle traces are built per instruction class from the sequencing rules.
module tb_multicycle_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [6:0]  opcode;
    logic        dec_reg_write = 1'b0;
    logic        dec_mem_read = 1'b0;
    logic        dec_mem_write = 1'b0;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        pc_en;
    logic [31:0] ir;
    logic [2:0]  state;
    logic        busy;
    logic        fault;
    logic        illegal;
    logic [31:0] retire_cnt;

    multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opcode(opcode),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .rf_we(rf_we), .pc_en(pc_en), .ir(ir),
        .state(state), .busy(busy), .fault(fault), .illegal(illegal),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [5:0] str;
        bit         iack;
        bit         dack;
        bit         dec;
        bit         runv;
    } cyc_t;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {imem_req, alu_en, dmem_req, dmem_we, rf_we, pc_en};
    endfunction

    function automatic logic [6:0] opc(input int cls);
        case (cls)
            0: return 7'h33;
            1: return 7'h03;
            2: return 7'h23;
            3: return 7'h63;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        run = 1'b1;
        #1;
        chk("kick_state", 64'(state), 64'd0);
        chk("kick_busy", 64'(busy), 64'd0);
        next_cycle();
    endtask

    // cls: 0 R-type, 1 load, 2 store, 3 branch, 4 unknown
    task automatic do_instr(input int cls, input int df, input int dm,
                            input bit run_after, input logic [31:0] fixed,
                            input string tag);
        cyc_t q[$];
        logic [31:0] r;
        logic [31:0] instr;
        bit rw;
        bit mr;
        bit mw;
        bit nop;
        r = $urandom();
        instr = (fixed != 0) ? fixed : {r[31:7], opc(cls)};
        rw  = (cls == 0) || (cls == 1);
        mr  = (cls == 1);
        mw  = (cls == 2);
        nop = !(rw || mr || mw);
        for (int i = 0; i < df; i++)
            q.push_back('{3'd1, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b1});
        q.push_back('{3'd1, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b1});
        q.push_back('{3'd2, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1});
        q.push_back('{3'd3, nop ? 6'b010001 : 6'b010000, 1'b0, 1'b0, 1'b0,
                      nop ? run_after : 1'b1});
        if (mr || mw) begin
            for (int i = 0; i < dm; i++)
                q.push_back('{3'd4, mw ? 6'b001100 : 6'b001000,
                              1'b0, 1'b0, 1'b0, run_after});
            q.push_back('{3'd4, mw ? 6'b001101 : 6'b001000,
                          1'b0, 1'b1, 1'b0, run_after});
        end
        if (rw)
            q.push_back('{3'd5, 6'b000011, 1'b0, 1'b0, 1'b0, run_after});
        foreach (q[k]) begin
            r = $urandom();
            imem_ack = (q[k].st == 3'd1) ? q[k].iack : r[0];
            dmem_ack = (q[k].st == 3'd4) ? q[k].dack : r[1];
            imem_rdata = q[k].iack ? instr : $urandom();
            if (q[k].dec)
                {dec_reg_write, dec_mem_read, dec_mem_write} = {rw, mr, mw};
            else
                {dec_reg_write, dec_mem_read, dec_mem_write} = r[4:2];
            run = q[k].runv;
            #1;
            chk({tag, "_state"}, 64'(state), 64'(q[k].st));
            chk({tag, "_strobes"}, 64'(strobes()), 64'(q[k].str));
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (q[k].st != 3'd1)
                chk({tag, "_ir"}, 64'(ir), 64'(instr));
            next_cycle();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_cnt++;
        chk({tag, "_retire_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
        chk({tag, "_after"}, 64'(state), run_after ? 64'd1 : 64'd0);
    endtask

    initial begin
        int cls;
        #12;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_cnt", 64'(retire_cnt), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_strobes", 64'(strobes()), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            #1;
            chk("idle_hold", 64'(state), 64'd0);
            chk("idle_noreq", 64'(imem_req), 64'd0);
            next_cycle();
        end
        imem_ack = 1'b0;
        kick();
        do_instr(0, 0, 0, 1'b1, 32'h002081B3, "add");
        do_instr(1, 0, 3, 1'b1, 32'h0000A103, "load");
        do_instr(2, 0, 1, 1'b1, 32'h0020A023, "store");
        do_instr(3, 0, 0, 1'b1, 32'h0, "branch");
        do_instr(0, TO - 1, 0, 1'b1, 32'h0, "fetch_edge");
        do_instr(2, 2, TO - 1, 1'b1, 32'h0, "mem_edge");
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 4));
`ifdef ILLEGAL_TRAP_EN
            if (cls == 4)
                cls = 3;
`endif
            do_instr(cls, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'b1, 32'h0, "rand");
        end
        do_instr(1, 1, 2, 1'b0, 32'h0, "drop");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drop_idle", 64'(state), 64'd0);
            chk("drop_noreq", 64'(imem_req), 64'd0);
            chk("drop_busy", 64'(busy), 64'd0);
            next_cycle();
        end
        kick();
`ifdef ILLEGAL_TRAP_EN
        imem_ack = 1'b1;
        imem_rdata = 32'h0000007F;
        #1;
        chk("ill_fetch", 64'(state), 64'd1);
        next_cycle();
        imem_ack = 1'b0;
        {dec_reg_write, dec_mem_read, dec_mem_write} = 3'b000;
        #1;
        chk("ill_decode", 64'(state), 64'd2);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            chk("ill_state", 64'(state), 64'd6);
            chk("ill_flag", 64'(illegal), 64'd1);
            chk("ill_strobes", 64'(strobes()), 64'd0);
            chk("ill_cnt", 64'(retire_cnt), 64'(exp_cnt));
            next_cycle();
        end
`else
        do_instr(4, 0, 0, 1'b1, 32'h0000007F, "nop7f");
        chk("nop_illegal", 64'(illegal), 64'd0);
`endif
        rst_n = 1'b0;
        #1;
        chk("areset_state", 64'(state), 64'd0);
        chk("areset_cnt", 64'(retire_cnt), 64'd0);
        chk("areset_illegal", 64'(illegal), 64'd0);
        exp_cnt = 0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        kick();
        for (int i = 0; i < TO; i++) begin
            imem_ack = 1'b0;
            #1;
            chk("to_state", 64'(state), 64'd1);
            chk("to_req", 64'(imem_req), 64'd1);
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            chk("fault_state", 64'(state), 64'd7);
            chk("fault_flag", 64'(fault), 64'd1);
            chk("fault_strobes", 64'(strobes()), 64'd0);
            chk("fault_busy", 64'(busy), 64'd0);
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        chk("fault_clr_state", 64'(state), 64'd0);
        chk("fault_clr_flag", 64'(fault), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
